// File: rtl/in_reg_bank_pkg.sv
// in_reg_bank_pkg: channel mode encoding and synchroniser depth limits for the input register bank
package in_reg_bank_pkg;
  typedef enum logic [1:0] {
    MODE_BYP  = 2'b00,
    MODE_REG  = 2'b01,
    MODE_SYNC = 2'b10,
    MODE_CAPT = 2'b11
  } mode_e;
  localparam int SYNC_MIN = 2;
  localparam int SYNC_MAX = 4;
endpackage

// File: rtl/in_reg_bank_chan.sv
// in_reg_bank_chan: one pad-to-fabric channel with shift chain, sticky rising-edge capture and output mux
module in_reg_bank_chan
  import in_reg_bank_pkg::*;
#(
  parameter int N = 2
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  en,
  input  logic  armed,
  input  logic  a2f,
  input  mode_e mode,
  input  logic  clr,
  output logic  iqz,
  output logic  edge_p
);
  logic [N-1:0] stage_q, stage_d;
  logic prev_q, prev_d, sticky_q, sticky_d, edge_q, edge_d, rise;
  always_comb begin
    rise     = stage_q[N-1] & ~prev_q & armed;
    stage_d  = en ? {stage_q[N-2:0], a2f} : stage_q;
    prev_d   = en ? stage_q[N-1] : prev_q;
    edge_d   = en & rise;
    // a new edge outranks a simultaneous clear so it is never lost
    sticky_d = edge_d | (~clr & sticky_q);
    iqz      = mode == MODE_BYP  ? a2f :
               mode == MODE_REG  ? stage_q[0] :
               mode == MODE_SYNC ? stage_q[N-1] : sticky_q;
    edge_p   = edge_q & (mode == MODE_CAPT);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q  <= '0;
      prev_q   <= 1'b0;
      sticky_q <= 1'b0;
      edge_q   <= 1'b0;
    end else begin
      stage_q  <= stage_d;
      prev_q   <= prev_d;
      sticky_q <= sticky_d;
      edge_q   <= edge_d;
    end
  end
endmodule

// File: rtl/in_reg_bank.sv
// in_reg_bank: WIDTH-channel IO input register bank with per-channel runtime mode and shared arming counter
module in_reg_bank
  import in_reg_bank_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic               IQC,
  input  logic               QRT,
  input  logic               IQE,
  input  logic [WIDTH-1:0]   A2F,
  input  logic [2*WIDTH-1:0] MODE,
  input  logic [WIDTH-1:0]   CLR,
  output logic [WIDTH-1:0]   IQZ,
  output logic [WIDTH-1:0]   EDGE
);
  localparam int CW = $clog2(SYNC_STAGES + 2);
  localparam logic [CW-1:0] ARM = CW'(SYNC_STAGES + 1);
  if (SYNC_STAGES < SYNC_MIN || SYNC_STAGES > SYNC_MAX) begin : g_bad_depth
    $error("in_reg_bank: SYNC_STAGES must be within 2..4");
  end
  logic [CW-1:0] cnt_q, cnt_d;
  logic armed;
  // edges are ignored until the chain and prev hold post-reset samples
  always_comb begin
    armed = cnt_q == ARM;
    cnt_d = (IQE && !armed) ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge IQC or posedge QRT) begin
    if (QRT) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    in_reg_bank_chan #(.N(SYNC_STAGES)) u_chan (
      .clk   (IQC),
      .rst   (QRT),
      .en    (IQE),
      .armed (armed),
      .a2f   (A2F[i]),
      .mode  (mode_e'(MODE[2*i+:2])),
      .clr   (CLR[i]),
      .iqz   (IQZ[i]),
      .edge_p(EDGE[i])
    );
  end
endmodule
